// File: rtl/upsample_stream.sv
// Nearest-neighbour 2-D upsampler: each input pixel is repeated SCALE times
// horizontally, and each buffered row is replayed SCALE times vertically.
module upsample_stream #(
  parameter int WIDTH     = 14,
  parameter int HEIGHT    = 14,
  parameter int SCALE     = 2,
  parameter int DATA_BITS = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_val,
  output logic                        in_rdy,
  input  logic [DATA_BITS-1:0]        data_in,
  output logic signed [DATA_BITS-1:0] data_out,
  output logic                        valid,
  output logic                        frame_done
);

  localparam int HB = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int CB = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int RB = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  localparam logic [HB-1:0] HMAX  = HB'(SCALE - 1);
  localparam logic [CB-1:0] CLAST = CB'(WIDTH - 1);
  localparam logic [RB-1:0] RLAST = RB'(HEIGHT - 1);

  typedef enum logic {LOAD, REPLAY} state_t;

  state_t               state;
  logic [CB-1:0]        col;
  logic [RB-1:0]        row;
  logic [HB-1:0]        hrep;
  logic [HB-1:0]        vrep;
  logic [DATA_BITS-1:0] linebuf [WIDTH];
  logic                 xfer;
  logic                 pix_done;

  always_comb begin
    in_rdy   = (state == LOAD) && (hrep == '0);
    xfer     = in_val && in_rdy;
    // Edge that emits the final horizontal copy of the current LOAD pixel.
    pix_done = (SCALE == 1) ? xfer : ((state == LOAD) && (hrep == HB'(1)));
  end

  always_ff @(posedge clk) begin
    if (xfer) linebuf[col] <= data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= LOAD;
      col        <= '0;
      row        <= '0;
      hrep       <= '0;
      vrep       <= '0;
      data_out   <= '0;
      valid      <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        LOAD: begin
          if (hrep != '0) begin
            valid <= 1'b1;
            hrep  <= hrep - 1'b1;
          end else if (in_val) begin
            data_out <= $signed(data_in);
            valid    <= 1'b1;
            hrep     <= HMAX;
          end else begin
            valid <= 1'b0;
          end

          // Entering REPLAY here preloads the first replay output for the next edge.
          if (pix_done) begin
            if (col == CLAST) begin
              col <= '0;
              if (SCALE > 1) begin
                state <= REPLAY;
                vrep  <= HMAX;
                hrep  <= HMAX;
              end else if (row == RLAST) begin
                row        <= '0;
                frame_done <= 1'b1;
              end else begin
                row <= row + 1'b1;
              end
            end else begin
              col <= col + 1'b1;
            end
          end
        end

        REPLAY: begin
          data_out <= $signed(linebuf[col]);
          valid    <= 1'b1;
          if (hrep != '0) begin
            hrep <= hrep - 1'b1;
          end else if (col == CLAST) begin
            col  <= '0;
            vrep <= vrep - 1'b1;
            if (vrep == HB'(1)) begin
              state <= LOAD;
              hrep  <= '0;
              if (row == RLAST) begin
                row        <= '0;
                frame_done <= 1'b1;
              end else begin
                row <= row + 1'b1;
              end
            end else begin
              hrep <= HMAX;
            end
          end else begin
            col  <= col + 1'b1;
            hrep <= HMAX;
          end
        end

        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: doc/upsample_stream.md
UPSAMPLE_STREAM -- requirements
Module: upsample_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 14, the input (pooled) row length in pixels.
REQ-002 SHALL have parameter HEIGHT, default 14, the input rows per frame.
REQ-003 SHALL have parameter SCALE, default 2, the integer upsample factor in each axis; the legal range is 1..8.
REQ-004 SHALL have parameter DATA_BITS, default 8, the pixel width.
REQ-005 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port in_val, input, 1 bit: an input pixel is offered.
REQ-008 SHALL have port in_rdy, output, 1 bit: the block can accept the pixel; a transfer occurs when in_val && in_rdy at a rising edge.
REQ-009 SHALL have port data_in, input, DATA_BITS: the input pixel, raster order.
REQ-010 SHALL have port data_out, output, DATA_BITS, signed: the upsampled pixel, raster order of a (WIDTH*SCALE) x (HEIGHT*SCALE) frame.
REQ-011 SHALL have port valid, output, 1 bit: data_out is valid this cycle; there is no output backpressure.
REQ-012 SHALL have port frame_done, output, 1 bit: one-cycle pulse coincident with the last output pixel of a frame.

Function
REQ-013 SHALL implement nearest-neighbour upsampling: input pixel (r,c) appears at output (r*SCALE+i, c*SCALE+j) for all i,j in 0..SCALE-1.
REQ-014 SHALL hold a single line buffer of WIDTH x DATA_BITS entries, plus a column counter, a row counter, hrep (horizontal repeat counter) and vrep (vertical pass counter).
REQ-015 SHALL use a two-state FSM, LOAD and REPLAY, with reset state LOAD.
REQ-016 In LOAD, SHALL drive in_rdy = (hrep == 0) combinationally; in REPLAY, in_rdy SHALL be 0.
REQ-017 On a LOAD transfer, SHALL at that same edge register data_out <= data_in, set valid <= 1, write linebuf[col] <= data_in, and set hrep <= SCALE-1.
REQ-018 Latency SHALL be one cycle, from the transfer edge to the first copy on data_out.
REQ-019 While hrep > 0 in LOAD, SHALL hold data_out with valid = 1 and decrement hrep each cycle.
REQ-020 Each accepted pixel SHALL therefore appear for exactly SCALE consecutive valid cycles.
REQ-021 In LOAD with hrep == 0 and in_val = 0, SHALL drive valid <= 0 and hold all state.
REQ-022 Back-to-back transfers SHALL produce a gap-free valid stream.
REQ-023 At the edge that emits the last copy of pixel col == WIDTH-1, SHALL go to REPLAY with col <= 0 and vrep <= SCALE-1; if SCALE == 1, SHALL skip REPLAY.
REQ-024 The first REPLAY output SHALL occur on the very next cycle, so there is no valid gap at the transition.
REQ-025 In REPLAY, SHALL emit linebuf[col] for SCALE cycles per column, then advance col.
REQ-026 At the end of each REPLAY pass, SHALL decrement vrep; when vrep reaches 0, SHALL increment row and return to LOAD.
REQ-027 When row == HEIGHT-1 completes, SHALL wrap row to 0 and assert frame_done with the final output pixel.
REQ-028 A new frame SHALL be accepted immediately afterwards, with no idle cycle required.
REQ-029 SHALL pass data bits unmodified, with no arithmetic; data_out is the reinterpretation of data_in as signed.
REQ-030 For SCALE = 1, SHALL behave as a one-cycle registered pass-through with in_rdy = 1, and frame_done SHALL pulse every WIDTH*HEIGHT transfers.
REQ-031 in_val while in_rdy = 0 SHALL have no effect; the source holds the pixel.

Reset
REQ-032 On rst_n low (asynchronous), SHALL set state LOAD, col = row = hrep = vrep = 0, data_out = 0, valid = 0, frame_done = 0; in_rdy SHALL then read 1.
REQ-033 Line buffer contents need not be reset.
REQ-034 Reset asserted mid-row or mid-REPLAY SHALL discard the partial frame; the first transfer after release SHALL be treated as pixel (0,0).

Verification
REQ-035 Scenario, WIDTH=2, HEIGHT=2, SCALE=2, in_val held high, inputs 1,2,3,4: the output SHALL be 1,1,2,2,1,1,2,2,3,3,4,4,3,3,4,4 on 16 contiguous valid cycles; frame_done SHALL be high only with the last 4; in_rdy SHALL be low for 4 cycles after each row.
REQ-036 Scenario, the same configuration with in_val toggling 1,0,1,0: each accepted pixel SHALL yield exactly 2 valid cycles; valid SHALL be low on idle cycles; no pixel SHALL be duplicated or lost.
REQ-037 Scenario, SCALE=1, inputs 5,-3 (0xFD): data_out SHALL be 5 then -3, one cycle after each transfer; in_rdy SHALL stay 1 throughout.
REQ-038 Scenario, rst_n pulsed low during the REPLAY of row 0, then inputs 7,8,9,10: the output SHALL be a complete clean frame starting with 7,7,8,8; valid SHALL be 0 during reset.
REQ-039 Scenario, two frames back-to-back with inputs 1..4 then 5..8: frame_done SHALL pulse once per frame; the second frame's first output SHALL be 5 with no gap after frame_done.
REQ-040 Scenario, WIDTH=3, SCALE=3, one row of inputs 1,2,3: the output SHALL be the 9-pixel sequence 1,1,1,2,2,2,3,3,3, emitted 3 times; in_rdy SHALL stay low for 18 cycles after the first pass.
